// File: rtl/vdu_mem_arbiter_if.sv
// Bundle of CPU, VDU and RAM-side signals around the display RAM arbiter.
// slave = arbiter side, master = requesters plus the RAM itself.
interface vdu_mem_arbiter_if #(
   parameter int ADDR_W = 9
);
   logic              cpu_req;
   logic              cpu_we;
   logic [15:0]       cpu_addr;
   logic [7:0]        cpu_wdata;
   logic [7:0]        cpu_rdata;
   logic              cpu_ack;
   logic              vdu_req;
   logic [15:0]       vdu_addr;
   logic [7:0]        vdu_rdata;
   logic              vdu_valid;
   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [7:0]        ram_wdata;
   logic [7:0]        ram_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vdu_req, vdu_addr, ram_rdata,
      output cpu_rdata, cpu_ack, vdu_rdata, vdu_valid, ram_en, ram_we, ram_addr, ram_wdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, vdu_req, vdu_addr, ram_rdata,
      input  cpu_rdata, cpu_ack, vdu_rdata, vdu_valid, ram_en, ram_we, ram_addr, ram_wdata
   );
endinterface

// File: rtl/vdu_mem_arbiter.sv
// Shares the single-port display RAM between CPU bus and VDU fetch, VDU first.
// Define ARB_STARVE_GUARD_EN to bound how long a waiting CPU can be starved.
module vdu_mem_arbiter #(
   parameter logic [15:0] BASE_ADDR   = 16'h0200,
   parameter int          ADDR_W      = 9,
   parameter int          MAX_VDU_RUN = 4
) (
   input logic              clk,
   input logic              rst_n,
   vdu_mem_arbiter_if.slave bus
);
   typedef enum logic [2:0] {IDLE, GNT_CPU, GNT_VDU, WAIT_CPU, WAIT_VDU, DONE} state_t;

   // 17-bit window bounds so a window ending at 'hFFFF cannot wrap
   localparam logic [16:0] WIN_LO = {1'b0, BASE_ADDR};
   localparam logic [16:0] WIN_HI = WIN_LO + 17'(2 ** ADDR_W);

   state_t            r_state;
   logic              r_cpuWe;
   logic              r_ramEn;
   logic              r_ramWe;
   logic [ADDR_W-1:0] r_ramAddr;
   logic [7:0]        r_ramWdata;
   logic              r_cpuAck;
   logic              r_vduValid;
   logic [7:0]        r_cpuRdata;
   logic [7:0]        r_vduRdata;

   logic [16:0]       w_cpuAddrExt;
   logic [16:0]       w_vduAddrExt;
   logic              w_cpuInWin;
   logic              w_vduInWin;
   logic [ADDR_W-1:0] w_cpuOffset;
   logic [ADDR_W-1:0] w_vduOffset;
   logic              w_pickVdu;

   assign w_cpuAddrExt = {1'b0, bus.cpu_addr};
   assign w_vduAddrExt = {1'b0, bus.vdu_addr};
   assign w_cpuInWin   = (w_cpuAddrExt >= WIN_LO) && (w_cpuAddrExt < WIN_HI);
   assign w_vduInWin   = (w_vduAddrExt >= WIN_LO) && (w_vduAddrExt < WIN_HI);
   assign w_cpuOffset  = w_cpuAddrExt[ADDR_W-1:0] - WIN_LO[ADDR_W-1:0];
   assign w_vduOffset  = w_vduAddrExt[ADDR_W-1:0] - WIN_LO[ADDR_W-1:0];

`ifdef ARB_STARVE_GUARD_EN
   localparam int               RUN_W   = $clog2(MAX_VDU_RUN + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_VDU_RUN);

   logic [RUN_W-1:0] r_vduRun;

   assign w_pickVdu = bus.vdu_req && !(bus.cpu_req && (r_vduRun == RUN_MAX));

   // Counts VDU grants taken while the CPU was waiting; any CPU grant resets it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vduRun <= '0;
      end else if (r_state == IDLE) begin
         if (w_pickVdu) begin
            if (!bus.cpu_req)
               r_vduRun <= '0;
            else if (r_vduRun != RUN_MAX)
               r_vduRun <= r_vduRun + RUN_W'(1);
         end else if (bus.cpu_req) begin
            r_vduRun <= '0;
         end
      end
   end
`else
   assign w_pickVdu = bus.vdu_req;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_cpuWe    <= 1'b0;
         r_ramEn    <= 1'b0;
         r_ramWe    <= 1'b0;
         r_ramAddr  <= '0;
         r_ramWdata <= 8'h00;
         r_cpuAck   <= 1'b0;
         r_vduValid <= 1'b0;
         r_cpuRdata <= 8'h00;
         r_vduRdata <= 8'h00;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_pickVdu) begin
                  if (w_vduInWin) begin
                     r_state   <= GNT_VDU;
                     r_ramEn   <= 1'b1;
                     r_ramWe   <= 1'b0;
                     r_ramAddr <= w_vduOffset;
                  end else begin
                     r_state    <= DONE;
                     r_vduValid <= 1'b1;
                     r_vduRdata <= 8'h00;
                  end
               end else if (bus.cpu_req) begin
                  r_cpuWe <= bus.cpu_we;
                  if (w_cpuInWin) begin
                     r_state    <= GNT_CPU;
                     r_ramEn    <= 1'b1;
                     r_ramWe    <= bus.cpu_we;
                     r_ramAddr  <= w_cpuOffset;
                     r_ramWdata <= bus.cpu_wdata;
                  end else begin
                     // Out-of-window: no RAM cycle, writes are simply dropped
                     r_state    <= DONE;
                     r_cpuAck   <= 1'b1;
                     r_cpuRdata <= 8'h00;
                  end
               end
            end
            GNT_CPU: begin
               r_ramEn <= 1'b0;
               r_ramWe <= 1'b0;
               if (r_cpuWe) begin
                  r_state  <= DONE;
                  r_cpuAck <= 1'b1;
               end else begin
                  r_state <= WAIT_CPU;
               end
            end
            GNT_VDU: begin
               r_ramEn <= 1'b0;
               r_ramWe <= 1'b0;
               r_state <= WAIT_VDU;
            end
            WAIT_CPU: begin
               r_state    <= DONE;
               r_cpuAck   <= 1'b1;
               r_cpuRdata <= bus.ram_rdata;
            end
            WAIT_VDU: begin
               r_state    <= DONE;
               r_vduValid <= 1'b1;
               r_vduRdata <= bus.ram_rdata;
            end
            DONE: begin
               r_state    <= IDLE;
               r_cpuAck   <= 1'b0;
               r_vduValid <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.ram_en    = r_ramEn;
   assign bus.ram_we    = r_ramWe;
   assign bus.ram_addr  = r_ramAddr;
   assign bus.ram_wdata = r_ramWdata;
   assign bus.cpu_ack   = r_cpuAck;
   assign bus.cpu_rdata = r_cpuRdata;
   assign bus.vdu_valid = r_vduValid;
   assign bus.vdu_rdata = r_vduRdata;
endmodule

// File: tb/tb_vdu_mem_arbiter.sv
// Bench for vdu_mem_arbiter: transaction-level reference model plus directed scenarios.
// Expectations for the guard scenario follow ARB_STARVE_GUARD_EN as compiled.
module tb_vdu_mem_arbiter;
   localparam logic [15:0] BASE   = 16'h0200;
   localparam int          AW     = 9;
   localparam int          MAXRUN = 4;
`ifdef ARB_STARVE_GUARD_EN
   localparam bit GUARD_ON = 1'b1;
`else
   localparam bit GUARD_ON = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   vdu_mem_arbiter_if #(.ADDR_W(AW)) bus();

   vdu_mem_arbiter #(
      .BASE_ADDR  (BASE),
      .ADDR_W     (AW),
      .MAX_VDU_RUN(MAXRUN)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int nChecks = 0;
   int nErrors = 0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nErrors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   // Display RAM behind the arbiter: one-cycle read latency
   logic [7:0] ramArr [0:511];
   logic [7:0] shadow [0:511];
   always @(posedge clk) begin
      if (bus.ram_en) begin
         if (bus.ram_we) ramArr[bus.ram_addr] <= bus.ram_wdata;
         else            bus.ram_rdata        <= ramArr[bus.ram_addr];
      end
   end

   function automatic bit inWindow(input logic [15:0] a);
      return (int'(a) >= int'(BASE)) && (int'(a) < int'(BASE) + (1 << AW));
   endfunction

   // Reference model: each accepted request occupies a fixed number of edges
   // (ack phase + DONE + IDLE) and produces its strobes at fixed phases.
   int          mCount    = 0;
   int          mPhase    = -1;
   int          mAckPhase = 0;
   int          runCnt    = 0;
   int          mOff      = 0;
   bit          mVdu      = 1'b0;
   bit          mInWin    = 1'b0;
   bit          mWrite    = 1'b0;
   logic [15:0] mAddr     = 16'h0;
   logic [7:0]  mWdata    = 8'h0;
   logic [7:0]  mReadVal  = 8'h0;
   logic        expEn = 1'b0, expWe = 1'b0, expCpuAck = 1'b0, expVduValid = 1'b0;
   logic [8:0]  expAddr     = 9'h0;
   logic [7:0]  expWdata    = 8'h0;
   logic [7:0]  expCpuRdata = 8'h0;
   logic [7:0]  expVduRdata = 8'h0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mCount = 0; mPhase = -1; runCnt = 0;
         expEn = 0; expWe = 0; expCpuAck = 0; expVduValid = 0;
         expCpuRdata = 8'h00; expVduRdata = 8'h00;
      end else begin
         if (mCount == 0) begin
            mPhase = -1;
            if (bus.cpu_req || bus.vdu_req) begin
               mVdu = bus.vdu_req && !(GUARD_ON && bus.cpu_req && runCnt == MAXRUN);
               if (mVdu) runCnt = bus.cpu_req ? ((runCnt < MAXRUN) ? runCnt + 1 : runCnt) : 0;
               else      runCnt = 0;
               mAddr     = mVdu ? bus.vdu_addr : bus.cpu_addr;
               mWrite    = !mVdu && bus.cpu_we;
               mWdata    = bus.cpu_wdata;
               mInWin    = inWindow(mAddr);
               mOff      = int'(mAddr) - int'(BASE);
               mAckPhase = !mInWin ? 0 : (mWrite ? 1 : 2);
               mCount    = mAckPhase + 1;
               mPhase    = 0;
               mReadVal  = 8'h00;
               if (mInWin && mWrite)  shadow[mOff] = mWdata;
               if (mInWin && !mWrite) mReadVal = shadow[mOff];
            end
         end else begin
            mCount--;
            mPhase++;
         end
         expEn = (mPhase == 0) && mInWin;
         expWe = expEn && mWrite;
         if (expEn) begin
            expAddr  = mOff[8:0];
            expWdata = mWdata;
         end
         expCpuAck   = (mPhase == mAckPhase) && !mVdu;
         expVduValid = (mPhase == mAckPhase) && mVdu;
         if (expCpuAck && (!mWrite || !mInWin)) expCpuRdata = mReadVal;
         if (expVduValid) expVduRdata = mReadVal;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         checkOutput("ram_en", bus.ram_en, expEn);
         checkOutput("cpu_ack", bus.cpu_ack, expCpuAck);
         checkOutput("vdu_valid", bus.vdu_valid, expVduValid);
         checkOutput("cpu_rdata", bus.cpu_rdata, expCpuRdata);
         checkOutput("vdu_rdata", bus.vdu_rdata, expVduRdata);
         if (expEn) begin
            checkOutput("ram_we", bus.ram_we, expWe);
            checkOutput("ram_addr", bus.ram_addr, expAddr);
            if (expWe) checkOutput("ram_wdata", bus.ram_wdata, expWdata);
         end
      end
   end

   bit enSeen = 1'b0;
   always @(negedge clk) if (bus.ram_en === 1'b1) enSeen = 1'b1;

   initial begin
      #300000;
      $display("[TB] FAIL watchdog actual=running expected=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic cpuAccess(input bit we, input logic [15:0] a, input logic [7:0] d,
                            output int lat, output logic [7:0] rd, output logic [8:0] gaddr);
      bit done = 1'b0;
      lat = 0; rd = 8'h00; gaddr = 9'h0;
      @(negedge clk);
      bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
      for (int c = 1; c <= 20 && !done; c++) begin
         @(negedge clk);
         if (c == 1) gaddr = bus.ram_addr;
         if (bus.cpu_ack) begin
            done = 1'b1; lat = c; rd = bus.cpu_rdata;
         end
      end
      bus.cpu_req = 1'b0;
      checkOutput("cpu ack seen", done, 1);
   endtask

   task automatic vduAccess(input logic [15:0] a, output int lat, output logic [7:0] rd);
      bit done = 1'b0;
      lat = 0; rd = 8'h00;
      @(negedge clk);
      bus.vdu_req = 1'b1; bus.vdu_addr = a;
      for (int c = 1; c <= 20 && !done; c++) begin
         @(negedge clk);
         if (bus.vdu_valid) begin
            done = 1'b1; lat = c; rd = bus.vdu_rdata;
         end
      end
      bus.vdu_req = 1'b0;
      checkOutput("vdu valid seen", done, 1);
   endtask

   task automatic applyStimulus();
      int lat, vT, cT, nValid, nAck, ack2T;
      logic [7:0] rd, vRd, cRd;
      logic [8:0] ga;
      bit gotAck, done;

      // Write then read back inside the window
      cpuAccess(1'b1, 16'h0205, 8'hA5, lat, rd, ga);
      checkOutput("wr ack latency", lat, 2);
      checkOutput("wr ram_addr", ga, 9'h005);
      cpuAccess(1'b0, 16'h0205, 8'h00, lat, rd, ga);
      checkOutput("rd ack latency", lat, 3);
      checkOutput("rd ram_addr", ga, 9'h005);
      checkOutput("rd data", rd, 8'hA5);

      // Simultaneous requests: VDU first, CPU right after
      @(negedge clk);
      bus.vdu_req = 1'b1; bus.vdu_addr = 16'h0200;
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0201;
      vT = 0; cT = 0; vRd = 8'h00; cRd = 8'h00;
      for (int c = 1; c <= 30 && (vT == 0 || cT == 0); c++) begin
         @(negedge clk);
         if (bus.vdu_valid && vT == 0) begin vT = c; vRd = bus.vdu_rdata; bus.vdu_req = 1'b0; end
         if (bus.cpu_ack && cT == 0)   begin cT = c; cRd = bus.cpu_rdata; bus.cpu_req = 1'b0; end
      end
      bus.vdu_req = 1'b0; bus.cpu_req = 1'b0;
      checkOutput("conc vdu cycle", vT, 3);
      checkOutput("conc cpu cycle", cT, 7);
      checkOutput("conc vdu data", vRd, 8'h5A);
      checkOutput("conc cpu data", cRd, 8'h5B);

      // Window boundaries
      enSeen = 1'b0;
      cpuAccess(1'b0, 16'h0400, 8'h00, lat, rd, ga);
      checkOutput("oow cpu latency", lat, 1);
      checkOutput("oow cpu data", rd, 8'h00);
      vduAccess(16'h01FF, lat, rd);
      checkOutput("oow vdu latency", lat, 1);
      checkOutput("oow vdu data", rd, 8'h00);
      checkOutput("oow ram_en seen", enSeen, 0);
      vduAccess(16'h03FF, lat, rd);
      checkOutput("top vdu latency", lat, 3);
      checkOutput("top vdu data", rd, 8'hA5);

      // VDU held high with CPU read pending
      @(negedge clk);
      bus.vdu_req = 1'b1; bus.vdu_addr = 16'h0210;
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0201;
      nValid = 0; gotAck = 1'b0;
      for (int c = 0; c < 40 && !gotAck; c++) begin
         @(negedge clk);
         if (bus.vdu_valid) nValid++;
         if (bus.cpu_ack) begin gotAck = 1'b1; bus.cpu_req = 1'b0; end
      end
      if (GUARD_ON) begin
         checkOutput("guard cpu ack", gotAck, 1);
         checkOutput("guard vdu count", nValid, MAXRUN);
      end else begin
         checkOutput("strict no cpu ack", gotAck, 0);
      end
      done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge clk);
         if (bus.vdu_valid) begin done = 1'b1; bus.vdu_req = 1'b0; end
      end
      checkOutput("starve vdu release", done, 1);
      bus.vdu_req = 1'b0;
      if (!gotAck) begin
         for (int c = 0; c < 20 && !gotAck; c++) begin
            @(negedge clk);
            if (bus.cpu_ack) gotAck = 1'b1;
         end
         checkOutput("starve cpu late ack", gotAck, 1);
      end
      bus.cpu_req = 1'b0;

      // Reset while the CPU read waits for RAM data
      @(negedge clk);
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0205;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("rst cpu_ack", bus.cpu_ack, 0);
      checkOutput("rst ram_en", bus.ram_en, 0);
      checkOutput("rst cpu_rdata", bus.cpu_rdata, 8'h00);
      checkOutput("rst vdu_rdata", bus.vdu_rdata, 8'h00);
      bus.cpu_req = 1'b0;
      gotAck = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (bus.cpu_ack) gotAck = 1'b1;
      end
      checkOutput("rst no ack", gotAck, 0);
      rst_n = 1'b1;
      cpuAccess(1'b0, 16'h0205, 8'h00, lat, rd, ga);
      checkOutput("post rst latency", lat, 3);
      checkOutput("post rst data", rd, 8'hA5);

      // Request held through DONE is served again
      @(negedge clk);
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0201;
      nAck = 0; ack2T = 0;
      for (int c = 1; c <= 20 && nAck < 2; c++) begin
         @(negedge clk);
         if (bus.cpu_ack) begin
            nAck++;
            if (nAck == 2) begin ack2T = c; bus.cpu_req = 1'b0; end
         end
      end
      bus.cpu_req = 1'b0;
      checkOutput("held req acks", nAck, 2);
      checkOutput("held req 2nd cycle", ack2T, 7);
      repeat (4) @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 512; i++) begin
         ramArr[i] = 8'(i) ^ 8'h5A;
         shadow[i] = 8'(i) ^ 8'h5A;
      end
      bus.ram_rdata = 8'h00;
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0; bus.cpu_wdata = 8'h0;
      bus.vdu_req = 1'b0; bus.vdu_addr = 16'h0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset cpu_ack", bus.cpu_ack, 0);
      checkOutput("reset vdu_valid", bus.vdu_valid, 0);
      checkOutput("reset ram_en", bus.ram_en, 0);
      checkOutput("reset ram_addr", bus.ram_addr, 9'h000);
      checkOutput("reset cpu_rdata", bus.cpu_rdata, 8'h00);
      rst_n = 1'b1;
      applyStimulus();
      $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
      $finish;
   end
endmodule
